// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared types, constants and ASCII-to-7-segment decode for the message scroller
//
// Purpose: scroller FSM state encoding, character/segment constants, and the
//          ascii_to_seg7 decode function used by every display decoder.
// Ports:   none (package)
package msg_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    FETCH = 2'd2
  } state_t;

  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEG_DP_ONLY = 8'h7F;
  localparam logic [7:0] SEG_APOS    = 8'hDF;

  // Returns {dp,g,f,e,d,c,b,a}, active-low. Lowercase folds onto uppercase glyphs.
  function automatic logic [7:0] ascii_to_seg7(input logic [7:0] c);
    logic [7:0] u;
    logic [6:0] on;  // active-high g..a
    u  = c;
    if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
    on = 7'h00;
    case (u)
      "0": on = 7'h3F;  "1": on = 7'h06;  "2": on = 7'h5B;  "3": on = 7'h4F;
      "4": on = 7'h66;  "5": on = 7'h6D;  "6": on = 7'h7D;  "7": on = 7'h07;
      "8": on = 7'h7F;  "9": on = 7'h6F;
      "A": on = 7'h77;  "B": on = 7'h7C;  "C": on = 7'h39;  "D": on = 7'h5E;
      "E": on = 7'h79;  "F": on = 7'h71;  "G": on = 7'h3D;  "H": on = 7'h76;
      "I": on = 7'h30;  "J": on = 7'h1E;  "K": on = 7'h75;  "L": on = 7'h38;
      "M": on = 7'h37;  "N": on = 7'h54;  "O": on = 7'h3F;  "P": on = 7'h73;
      "Q": on = 7'h67;  "R": on = 7'h50;  "S": on = 7'h6D;  "T": on = 7'h78;
      "U": on = 7'h3E;  "V": on = 7'h1C;  "W": on = 7'h2A;  "X": on = 7'h76;
      "Y": on = 7'h6E;  "Z": on = 7'h5B;
      default: on = 7'h00;
    endcase
    if (u == 8'h27)      return SEG_APOS;
    else if (u == 8'h2E) return SEG_DP_ONLY;
    else                 return {1'b1, ~on};
  endfunction

endpackage

// File: rtl/ascii_seg7_dec.sv
// rtl/ascii_seg7_dec.sv - registered ASCII to active-low 7-segment decoder for one display
//
// Purpose: decode one window character every cycle into {dp,g..a}, active-low.
// Ports:   i_clk    clock, rising edge
//          i_reset  async active-high reset (output blanks)
//          i_char   ASCII character
//          o_seg_n  registered segment pattern, active-low
module ascii_seg7_dec
  import msg_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_char,
  output logic [7:0] o_seg_n
);

  logic [7:0] r_seg_n;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_seg_n <= SEG_BLANK;
    else         r_seg_n <= ascii_to_seg7(i_char);
  end

  assign o_seg_n = r_seg_n;

endmodule

// File: rtl/message_scroller.sv
// rtl/message_scroller.sv - reads the message ROM into a character window and scrolls it onto 7-seg displays
//
// Purpose: fills a NUM_DISP-character window from ROM address 0, then on every
//          scroll tick fetches one new character and shifts the window by one.
// Optional: MSG_SCROLL_DIR_EN adds i_dir (0 = scroll left, 1 = scroll right).
// Ports:   i_clk       clock, rising edge
//          i_reset     async active-high reset
//          i_enable    1 = tick counter runs, 0 = freeze
//          i_restart   sync pulse, reload the window from address 0
//          i_dir       scroll direction (MSG_SCROLL_DIR_EN only)
//          o_rom_addr  registered ROM read address
//          i_rom_data  ROM byte at o_rom_addr (combinational ROM)
//          o_hex_n     registered active-low {dp,g..a} per display, [7:0] = rightmost
//          o_head      ROM address of the leftmost displayed character
//          o_ready     window loaded, scrolling active
module message_scroller
  import msg_pkg::*;
#(
  parameter int NUM_DISP = 6,
  parameter int MSG_LEN  = 16,
  parameter int ADDR_W   = 4,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_restart,
`ifdef MSG_SCROLL_DIR_EN
  input  logic                  i_dir,
`endif
  output logic [ADDR_W-1:0]     o_rom_addr,
  input  logic [7:0]            i_rom_data,
  output logic [NUM_DISP*8-1:0] o_hex_n,
  output logic [ADDR_W-1:0]     o_head,
  output logic                  o_ready
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int FILL_W = $clog2(NUM_DISP + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_DISP);
  localparam logic [ADDR_W-1:0] DISP_OFS  = ADDR_W'(NUM_DISP);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MSG_LEN - 1);

  state_t            r_state, w_next_state;
  logic [FILL_W-1:0] r_fill_cnt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [ADDR_W-1:0] r_rom_addr, r_head;
  logic              r_ready;
  logic              r_dir;  // direction captured at the tick, applied by the following FETCH
  logic [7:0]        r_window [NUM_DISP];  // index NUM_DISP-1 = leftmost

  logic w_tick, w_dir, w_fill_step, w_fill_shift, w_fill_done, w_issue, w_capture;

`ifdef MSG_SCROLL_DIR_EN
  assign w_dir = i_dir;
`else
  assign w_dir = 1'b0;
`endif

  assign w_tick = i_enable && r_ready && (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= FILL;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (i_restart) begin
      w_next_state = FILL;
    end else begin
      case (r_state)
        FILL:    if (r_fill_cnt == FILL_LAST) w_next_state = WAIT;
        WAIT:    if (w_tick) w_next_state = FETCH;
        FETCH:   w_next_state = WAIT;
        default: w_next_state = FILL;
      endcase
    end
  end

  // restart suppresses every datapath strobe, so it wins over a pending capture
  always_comb begin
    w_fill_step  = 1'b0;
    w_fill_shift = 1'b0;
    w_fill_done  = 1'b0;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    if (!i_restart) begin
      case (r_state)
        FILL: begin
          w_fill_step  = 1'b1;
          w_fill_shift = (r_fill_cnt != '0);  // byte for address k-1 arrives in cycle k
          w_fill_done  = (r_fill_cnt == FILL_LAST);
        end
        WAIT:    w_issue   = w_tick;
        FETCH:   w_capture = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fill_cnt <= '0;
      r_tick_cnt <= '0;
      r_rom_addr <= '0;
      r_head     <= '0;
      r_ready    <= 1'b0;
      r_dir      <= 1'b0;
      for (int i = 0; i < NUM_DISP; i++) r_window[i] <= CHAR_SPACE;
    end else if (i_restart) begin
      r_fill_cnt <= '0;
      r_tick_cnt <= '0;
      r_rom_addr <= '0;
      r_head     <= '0;
      r_ready    <= 1'b0;
      r_dir      <= 1'b0;
      for (int i = 0; i < NUM_DISP; i++) r_window[i] <= CHAR_SPACE;
    end else begin
      if (w_tick)                   r_tick_cnt <= '0;
      else if (i_enable && r_ready) r_tick_cnt <= r_tick_cnt + 1'b1;

      if (w_fill_step && !w_fill_done) begin
        r_rom_addr <= ADDR_W'(r_fill_cnt);
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      if (w_fill_done) begin
        r_ready <= 1'b1;
        r_head  <= '0;
      end

      if (w_fill_shift || (w_capture && !r_dir)) begin
        for (int i = NUM_DISP - 1; i > 0; i--) r_window[i] <= r_window[i-1];
        r_window[0] <= i_rom_data;
      end else if (w_capture && r_dir) begin
        for (int i = 0; i < NUM_DISP - 1; i++) r_window[i] <= r_window[i+1];
        r_window[NUM_DISP-1] <= i_rom_data;
      end

      if (w_issue) begin
        r_dir      <= w_dir;
        r_rom_addr <= w_dir ? ((r_head - 1'b1) & ADDR_MASK)
                            : ((r_head + DISP_OFS) & ADDR_MASK);
      end
      if (w_capture) begin
        r_head <= r_dir ? ((r_head - 1'b1) & ADDR_MASK)
                        : ((r_head + 1'b1) & ADDR_MASK);
      end
    end
  end

  for (genvar g = 0; g < NUM_DISP; g++) begin : g_dec
    ascii_seg7_dec u_dec (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_char  (r_window[g]),
      .o_seg_n (o_hex_n[8*g +: 8])
    );
  end

  assign o_rom_addr = r_rom_addr;
  assign o_head     = r_head;
  assign o_ready    = r_ready;

endmodule

// File: tb/tb_message_scroller.sv
// tb/tb_message_scroller.sv - directed self-checking bench for message_scroller
module tb_message_scroller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        restart = 1'b0;
`ifdef MSG_SCROLL_DIR_EN
  logic        dir = 1'b0;
`endif
  logic [3:0]  rom_addr, head;
  logic [7:0]  rom_data;
  logic [47:0] hex_n;
  logic        ready;

  // "'' HELLO CLIP.''"
  logic [7:0] rom [16] = '{8'h27, 8'h27, 8'h20, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F,
                           8'h20, 8'h43, 8'h4C, 8'h49, 8'h50, 8'h2E, 8'h27, 8'h27};

  // hand-decoded displays, leftmost in the top byte
  localparam logic [47:0] HEX_BLANK = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] HEX_INIT  = 48'hDFDF_FF89_86C7;  // ' ' _ H E L
  localparam logic [47:0] HEX_P12   = 48'h8C7F_DFDF_DFDF;  // P . ' ' ' '
  localparam logic [47:0] HEX_RIGHT = 48'hDFDF_DFFF_8986;  // ' ' ' _ H E

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  message_scroller #(
    .NUM_DISP (6),
    .MSG_LEN  (16),
    .ADDR_W   (4),
    .TICK_DIV (4)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_enable   (enable),
    .i_restart  (restart),
`ifdef MSG_SCROLL_DIR_EN
    .i_dir      (dir),
`endif
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .o_hex_n    (hex_n),
    .o_head     (head),
    .o_ready    (ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_ready", ready, 0);
    check("rst_hex", hex_n, HEX_BLANK);
    check("rst_addr", rom_addr, 0);
    check("rst_head", head, 0);
    reset = 1'b0;

    step(6);
    check("fill_ready_early", ready, 0);
    step(1);
    check("fill_ready", ready, 1);
    step(1);
    check("fill_hex", hex_n, HEX_INIT);
    check("fill_head", head, 0);

    // tick k lands 4k edges after ready
    step(43);
    check("wrap_fetch_addr", rom_addr, 0);
    check("wrap_head", head, 10);
    step(4);
    check("tick12_addr", rom_addr, 1);
    enable = 1'b0;
    step(2);
    check("tick12_head", head, 12);
    check("tick12_hex", hex_n, HEX_P12);
    for (int i = 0; i < 18; i++) begin
      step(1);
      check("freeze_addr", rom_addr, 1);
      check("freeze_head", head, 12);
    end
    check("freeze_hex", hex_n, HEX_P12);
    enable = 1'b1;
    step(3);
    check("reenable_no_early_tick", rom_addr, 1);
    step(1);
    check("reenable_tick", rom_addr, 2);

    // restart lands on the FETCH capture edge
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_ready", ready, 0);
    check("restart_head", head, 0);
    step(1);
    check("restart_hex_blank", hex_n, HEX_BLANK);
    check("restart_ready_1", ready, 0);
    step(5);
    check("restart_ready_6", ready, 0);
    step(1);
    check("refill_ready", ready, 1);
    step(1);
    check("refill_hex", hex_n, HEX_INIT);
    step(3);
    check("refill_tick_addr", rom_addr, 6);

    // now in FETCH: async reset without a clock edge
    #2;
    reset = 1'b1;
    #1;
    check("async_hex", hex_n, HEX_BLANK);
    check("async_addr", rom_addr, 0);
    check("async_ready", ready, 0);
    check("async_head", head, 0);
    #2;
    reset = 1'b0;

`ifdef MSG_SCROLL_DIR_EN
    step(7);
    check("dir_fill_ready", ready, 1);
    dir = 1'b1;
    step(4);
    check("dir_addr", rom_addr, 15);
    step(1);
    check("dir_head", head, 15);
    step(1);
    check("dir_hex", hex_n, HEX_RIGHT);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
